// File: rtl/servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_multi
// Brief    : NUM_CH servo PWM outputs from one frame counter, double-buffered
//            widths, per-frame update FSM. Optional slew: SERVO_SLEW_EN.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module servo_pwm_multi #(
  parameter int NUM_CH        = 4,
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int MIN_PULSE     = 40_000,
  parameter int MAX_PULSE     = 100_000,
  parameter int POS_W         = 8,
  parameter int POS_MAX       = 100,
  parameter int POS_DEFAULT   = 25,
  parameter int CNT_W         = 20,
  parameter int SLEW_STEP     = 10,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_valid,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [POS_W-1:0]  wr_pos,
  output logic              wr_ready,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              busy
);

  function automatic logic [CNT_W-1:0] width_of(input logic [POS_W-1:0] p);
    logic [63:0] span;
    span = 64'(MAX_PULSE - MIN_PULSE) * 64'(p);
    return CNT_W'(64'(MIN_PULSE) + span / 64'(POS_MAX));
  endfunction

  localparam logic [CNT_W-1:0] c_last    = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [POS_W-1:0] c_pos_max = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] c_pos_def = POS_W'(POS_DEFAULT);
  localparam logic [CNT_W-1:0] c_w_def   = width_of(c_pos_def);
  localparam logic [CH_W-1:0]  c_ch_last = CH_W'(NUM_CH - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CH_W-1:0]     r_idx;
  logic [POS_W-1:0]    r_target  [NUM_CH];
  logic [POS_W-1:0]    r_cur     [NUM_CH];
  logic [CNT_W-1:0]    r_pending [NUM_CH];
  logic [CNT_W-1:0]    r_active  [NUM_CH];
  logic [NUM_CH-1:0]   r_pwm;

  logic                w_wr_fire;
  logic                w_ch_ok;
  logic [POS_W-1:0]    w_wr_pos;
  logic [POS_W-1:0]    w_cur;
  logic [POS_W-1:0]    w_tgt;
  logic [POS_W-1:0]    w_next;
  logic [CNT_W-1:0]    w_next_w;

  assign wr_ready    = (r_state == S_IDLE) && (r_cnt > CNT_W'(NUM_CH));
  assign frame_start = (r_cnt == '0);
  assign busy        = (r_state == S_UPDATE);
  assign pwm_out     = r_pwm;

  assign w_wr_fire = wr_valid && wr_ready;
  assign w_ch_ok   = (32'(wr_ch) < NUM_CH);
  assign w_wr_pos  = (wr_pos > c_pos_max) ? c_pos_max : wr_pos;
  assign w_cur     = r_cur[r_idx];
  assign w_tgt     = r_target[r_idx];

`ifdef SERVO_SLEW_EN
  localparam logic [POS_W-1:0] c_step = POS_W'(SLEW_STEP);
  logic [POS_W-1:0] w_diff;
  always_comb begin
    w_next = w_tgt;
    w_diff = '0;
    if (w_tgt > w_cur) begin
      w_diff = w_tgt - w_cur;
      if (w_diff > c_step) w_next = w_cur + c_step;
    end else if (w_cur > w_tgt) begin
      w_diff = w_cur - w_tgt;
      if (w_diff > c_step) w_next = w_cur - c_step;
    end
  end
`else
  always_comb begin
    w_next = w_tgt;
  end
`endif

  assign w_next_w = width_of(w_next);

  // Frame counter, width double-buffering, write capture and update FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_idx   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_target[i]  <= c_pos_def;
        r_cur[i]     <= c_pos_def;
        r_pending[i] <= c_w_def;
        r_active[i]  <= c_w_def;
      end
    end else begin
      if (r_cnt == c_last) begin
        r_cnt <= '0;
        for (int i = 0; i < NUM_CH; i++) r_active[i] <= r_pending[i];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_wr_fire && w_ch_ok) r_target[wr_ch] <= w_wr_pos;

      case (r_state)
        S_IDLE: begin
          if (r_cnt == '0) begin
            r_state <= S_UPDATE;
            r_idx   <= '0;
          end
        end
        S_UPDATE: begin
          r_cur[r_idx]     <= w_next;
          r_pending[r_idx] <= w_next_w;
          if (r_idx == c_ch_last) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pwm
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pwm[g] <= 1'b0;
      else     r_pwm[g] <= en[g] && (r_cnt < r_active[g]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_multi
// Brief    : Directed bench, 200-cycle frames with W(p)=20+p; NUM_CH=4 and 3.
// Revision : 1.0 - initial
// ============================================================================
module tb_servo_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic       wr_valid;
  logic [1:0] wr_ch;
  logic [7:0] wr_pos;
  logic       wr_ready;
  logic [3:0] pwm_out;
  logic       frame_start;
  logic       busy;

  logic [2:0] en3;
  logic       wr_valid3;
  logic [1:0] wr_ch3;
  logic [7:0] wr_pos3;
  logic       wr_ready3;
  logic [2:0] pwm3;
  logic       frame_start3;
  logic       busy3;

  int checks = 0;
  int errors = 0;
  int hi[4];
  int hi3[3];
  int fs_cnt;
  logic rdy;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(4), .PERIOD_CYCLES(200), .MIN_PULSE(20), .MAX_PULSE(120),
    .POS_W(8), .POS_MAX(100), .POS_DEFAULT(25), .CNT_W(8), .SLEW_STEP(10)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ch(wr_ch),
    .wr_pos(wr_pos), .wr_ready(wr_ready), .pwm_out(pwm_out),
    .frame_start(frame_start), .busy(busy)
  );

  servo_pwm_multi #(
    .NUM_CH(3), .PERIOD_CYCLES(200), .MIN_PULSE(20), .MAX_PULSE(120),
    .POS_W(8), .POS_MAX(100), .POS_DEFAULT(25), .CNT_W(8), .SLEW_STEP(10)
  ) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .wr_valid(wr_valid3), .wr_ch(wr_ch3),
    .wr_pos(wr_pos3), .wr_ready(wr_ready3), .pwm_out(pwm3),
    .frame_start(frame_start3), .busy(busy3)
  );

  // Called at the cnt==0 sample; counts high samples over one frame.
  task automatic measure();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    for (int i = 0; i < 3; i++) hi3[i] = 0;
    fs_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 4; i++) if (pwm_out[i]) hi[i]++;
      for (int i = 0; i < 3; i++) if (pwm3[i]) hi3[i]++;
      if (frame_start) fs_cnt++;
      @(negedge clk);
    end
  endtask

  // Called at cnt==0 of frame N; writes at cnt==50, returns at cnt==0 of N+1.
  task automatic write_at50(input bit to3, input logic [1:0] ch,
                            input logic [7:0] pos, output logic ready_seen);
    repeat (50) @(negedge clk);
    if (to3) begin
      wr_valid3 = 1'b1; wr_ch3 = ch; wr_pos3 = pos; ready_seen = wr_ready3;
    end else begin
      wr_valid = 1'b1; wr_ch = ch; wr_pos = pos; ready_seen = wr_ready;
    end
    @(negedge clk);
    wr_valid = 1'b0; wr_valid3 = 1'b0;
    repeat (149) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'b1111; en3 = 3'b111;
    wr_valid = 1'b0; wr_ch = '0; wr_pos = '0;
    wr_valid3 = 1'b0; wr_ch3 = '0; wr_pos3 = '0;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reset_fs: got %b expected 1", frame_start); end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (wr_ready !== (c > 4)) begin errors++; $display("FAIL ready_cnt%0d: got %b expected %b", c, wr_ready, (c > 4)); end
      checks++;
      if (busy !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL busy_cnt%0d: got %b expected %b", c, busy, (c >= 1 && c <= 4)); end
      @(negedge clk);
    end
    repeat (194) @(negedge clk);
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++; if (hi[i] !== 45) begin errors++; $display("FAIL default_width ch%0d: got %0d expected 45", i, hi[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (hi3[i] !== 45) begin errors++; $display("FAIL default_width3 ch%0d: got %0d expected 45", i, hi3[i]); end
    end
    checks++; if (fs_cnt !== 1) begin errors++; $display("FAIL fs_per_frame: got %0d expected 1", fs_cnt); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_period: got %b expected 1", frame_start); end
  endtask

  task automatic test_write_latency();
    int exp2 [3];
`ifdef SERVO_SLEW_EN
    exp2 = '{45, 55, 65};
`else
    exp2 = '{45, 100, 100};
`endif
    write_at50(1'b0, 2'd2, 8'd80, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready_cnt50: got %b expected 1", rdy); end
    for (int f = 0; f < 3; f++) begin
      measure();
      checks++; if (hi[2] !== exp2[f]) begin errors++; $display("FAIL write_ch2 frame+%0d: got %0d expected %0d", f + 1, hi[2], exp2[f]); end
      checks++; if (hi[0] !== 45) begin errors++; $display("FAIL write_other frame+%0d: got %0d expected 45", f + 1, hi[0]); end
    end
  endtask

  task automatic test_enable();
    repeat (10) @(negedge clk);
    en[1] = 1'b0;
    @(negedge clk);
    checks++; if (pwm_out[1] !== 1'b0) begin errors++; $display("FAIL en_off_next: got %b expected 0", pwm_out[1]); end
    checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL en_other_high: got %b expected 1", pwm_out[0]); end
    repeat (189) @(negedge clk);
    measure();
    checks++; if (hi[1] !== 0) begin errors++; $display("FAIL en_off_frame: got %0d expected 0", hi[1]); end
    checks++; if (hi[3] !== 45) begin errors++; $display("FAIL en_off_other: got %0d expected 45", hi[3]); end
    en[1] = 1'b1;
    measure();
    checks++; if (hi[1] !== 45) begin errors++; $display("FAIL en_resume: got %0d expected 45", hi[1]); end
  endtask

  task automatic test_clamp();
    int exp1;
`ifdef SERVO_SLEW_EN
    exp1 = 55;
`else
    exp1 = 120;
`endif
    write_at50(1'b0, 2'd1, 8'd200, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL clamp_ready: got %b expected 1", rdy); end
    measure();
    checks++; if (hi[1] !== 45) begin errors++; $display("FAIL clamp_frame1: got %0d expected 45", hi[1]); end
    measure();
    checks++; if (hi[1] !== exp1) begin errors++; $display("FAIL clamp_frame2: got %0d expected %0d", hi[1], exp1); end
  endtask

  task automatic test_discard();
    write_at50(1'b1, 2'd3, 8'd80, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL discard_ready: got %b expected 1", rdy); end
    measure();
    measure();
    for (int i = 0; i < 3; i++) begin
      checks++; if (hi3[i] !== 45) begin errors++; $display("FAIL discard ch%0d: got %0d expected 45", i, hi3[i]); end
    end
  endtask

  task automatic test_slew();
    int exp0 [6];
`ifdef SERVO_SLEW_EN
    exp0 = '{45, 55, 65, 75, 85, 85};
`else
    exp0 = '{45, 85, 85, 85, 85, 85};
`endif
    write_at50(1'b0, 2'd0, 8'd65, rdy);
    for (int f = 0; f < 6; f++) begin
      measure();
      checks++; if (hi[0] !== exp0[f]) begin errors++; $display("FAIL slew_ch0 frame+%0d: got %0d expected %0d", f + 1, hi[0], exp0[f]); end
    end
  endtask

  task automatic test_back_to_back_and_reset();
    int exp3;
`ifdef SERVO_SLEW_EN
    exp3 = 55;
`else
    exp3 = 100;
`endif
    repeat (50) @(negedge clk);
    wr_valid = 1'b1; wr_ch = 2'd3; wr_pos = 8'd10;
    @(negedge clk);
    wr_pos = 8'd80;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (148) @(negedge clk);
    measure();
    checks++; if (hi[3] !== 45) begin errors++; $display("FAIL b2b_frame1: got %0d expected 45", hi[3]); end
    measure();
    checks++; if (hi[3] !== exp3) begin errors++; $display("FAIL b2b_last_wins: got %0d expected %0d", hi[3], exp3); end
    repeat (120) @(negedge clk);
`ifndef SERVO_SLEW_EN
    checks++; if (pwm_out[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_ch1: got %b expected 1", pwm_out[1]); end
`endif
    rst = 1'b1;
    #1;
    checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL midframe_rst_pwm: got %b expected 0000", pwm_out); end
    checks++; if (pwm3 !== 3'b000) begin errors++; $display("FAIL midframe_rst_pwm3: got %b expected 000", pwm3); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_cnt_restart: got %b expected 1", frame_start); end
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++; if (hi[i] !== 45) begin errors++; $display("FAIL post_rst ch%0d: got %0d expected 45", i, hi[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_enable();
    test_clamp();
    test_discard();
    test_slew();
    test_back_to_back_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
